// File: rtl/nnrv_pkg.sv
// Shared definitions for the nnrv core: op-type encodings (common with the decoder),
// the EX state enum and the default datapath width.
package nnrv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;

  typedef enum logic {
    EX_IDLE  = 1'b0,
    EX_SHIFT = 1'b1
  } ex_state_t;

endpackage

// File: rtl/nnrv_alu.sv
// Purpose: combinational ALU for the EX stage plus a 1-bit shift step (or a barrel shifter).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; NNRV_EX_FAST_SHIFT_EN selects the barrel shifter and removes the step port.
module nnrv_alu
  import nnrv_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = 5
) (
  input  logic [3:0]      i_type,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_res
`ifndef NNRV_EX_FAST_SHIFT_EN
  ,
  input  logic [3:0]      i_step_type,
  input  logic [XLEN-1:0] i_step_val,
  output logic [XLEN-1:0] o_step_res
`endif
);

  always_comb begin
    o_res = '0;
    case (i_type)
      OP_ADD:  o_res = i_a + i_b;
      OP_SUB:  o_res = i_a - i_b;
      OP_SLT:  o_res = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU: o_res = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      OP_XOR:  o_res = i_a ^ i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_AND:  o_res = i_a & i_b;
`ifdef NNRV_EX_FAST_SHIFT_EN
      OP_SLL:  o_res = i_a << i_b[SHAMT_W-1:0];
      OP_SRL:  o_res = i_a >> i_b[SHAMT_W-1:0];
      OP_SRA:  o_res = $unsigned($signed(i_a) >>> i_b[SHAMT_W-1:0]);
`else
      // Only reached for a zero shift amount; non-zero shifts go through the step path.
      OP_SLL, OP_SRL, OP_SRA: o_res = i_a;
`endif
      default: o_res = '0;
    endcase
  end

`ifndef NNRV_EX_FAST_SHIFT_EN
  always_comb begin
    o_step_res = i_step_val;
    case (i_step_type)
      OP_SLL:  o_step_res = {i_step_val[XLEN-2:0], 1'b0};
      OP_SRL:  o_step_res = {1'b0, i_step_val[XLEN-1:1]};
      OP_SRA:  o_step_res = {i_step_val[XLEN-1], i_step_val[XLEN-1:1]};
      default: o_step_res = i_step_val;
    endcase
  end
`endif

endmodule

// File: rtl/nnrv_ex.sv
// Purpose: nnrv execute stage, ID handshake, ALU issue and registered write-back pulse.
// Latency: 1 cycle; shifts take shamt cycles unless NNRV_EX_FAST_SHIFT_EN (barrel, always 1).
// Backpressure: o_id_ready low while an iterative shift is in progress.
module nnrv_ex
  import nnrv_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_id_valid,
  output logic            o_id_ready,
  input  logic [XLEN-1:0] i_id_op1,
  input  logic [XLEN-1:0] i_id_op2,
  input  logic [3:0]      i_id_type,
  input  logic [4:0]      i_id_rd,
  output logic            o_wb_en,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_busy
);

  logic            xfer;
  logic            op_known;
  logic [XLEN-1:0] alu_res;
  logic            wb_en_d;
  logic [4:0]      wb_rd_d;
  logic [XLEN-1:0] wb_data_d;

  assign xfer     = i_id_valid && o_id_ready;
  assign op_known = (i_id_type >= OP_ADD) && (i_id_type <= OP_SRA);

`ifdef NNRV_EX_FAST_SHIFT_EN

  nnrv_alu #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_alu (
    .i_type (i_id_type),
    .i_a    (i_id_op1),
    .i_b    (i_id_op2),
    .o_res  (alu_res)
  );

  assign o_id_ready = 1'b1;
  assign o_busy     = 1'b0;

  always_comb begin
    wb_en_d   = 1'b0;
    wb_rd_d   = o_wb_rd;
    wb_data_d = o_wb_data;
    if (xfer && op_known && (i_id_rd != 5'd0)) begin
      wb_en_d   = 1'b1;
      wb_rd_d   = i_id_rd;
      wb_data_d = alu_res;
    end
  end

`else

  ex_state_t          state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]    work_q, work_d;
  logic [3:0]         type_q, type_d;
  logic [4:0]         rd_q, rd_d;
  logic [XLEN-1:0]    step_val, step_res;
  logic [3:0]         step_type;
  logic               is_shift;
  logic [SHAMT_W-1:0] shamt_in;

  assign is_shift = (i_id_type == OP_SLL) || (i_id_type == OP_SRL) || (i_id_type == OP_SRA);
  assign shamt_in = i_id_op2[SHAMT_W-1:0];

  nnrv_alu #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_alu (
    .i_type      (i_id_type),
    .i_a         (i_id_op1),
    .i_b         (i_id_op2),
    .o_res       (alu_res),
    .i_step_type (step_type),
    .i_step_val  (step_val),
    .o_step_res  (step_res)
  );

  assign o_id_ready = (state_q == EX_IDLE);
  assign o_busy     = (state_q != EX_IDLE);

  // The first shift step is taken on the accept edge, so SHIFT lasts shamt-1 cycles
  // and the write-back lands exactly shamt cycles after acceptance.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    type_d    = type_q;
    rd_d      = rd_q;
    step_val  = work_q;
    step_type = type_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = o_wb_rd;
    wb_data_d = o_wb_data;
    case (state_q)
      EX_IDLE: begin
        step_val  = i_id_op1;
        step_type = i_id_type;
        if (xfer) begin
          if (is_shift && (shamt_in > SHAMT_W'(1))) begin
            state_d = EX_SHIFT;
            cnt_d   = shamt_in - SHAMT_W'(1);
            work_d  = step_res;
            type_d  = i_id_type;
            rd_d    = i_id_rd;
          end else if (op_known && (i_id_rd != 5'd0)) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = i_id_rd;
            wb_data_d = (is_shift && (shamt_in == SHAMT_W'(1))) ? step_res : alu_res;
          end
        end
      end
      EX_SHIFT: begin
        work_d = step_res;
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = EX_IDLE;
          cnt_d   = '0;
          if (rd_q != 5'd0) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = rd_q;
            wb_data_d = step_res;
          end
        end else begin
          cnt_d = cnt_q - SHAMT_W'(1);
        end
      end
      default: state_d = EX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= EX_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      type_q  <= OP_NOP;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      type_q  <= type_d;
      rd_q    <= rd_d;
    end
  end

`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_wb_en   <= 1'b0;
      o_wb_rd   <= '0;
      o_wb_data <= '0;
    end else begin
      o_wb_en   <= wb_en_d;
      o_wb_rd   <= wb_rd_d;
      o_wb_data <= wb_data_d;
    end
  end

endmodule
